// File: rtl/wb_arbiter.sv
// Write-back arbiter for the register file write port: pipeline writeback has
// absolute priority, two long-latency units share the rest round-robin.
module wb_arbiter #(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 32,
    parameter int STARVE_LIM = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_we_i,
    input  logic [REG_ADDR_W-1:0] pipe_waddr_i,
    input  logic [DATA_W-1:0]     pipe_wdata_i,
    input  logic                  u1_valid_i,
    input  logic [REG_ADDR_W-1:0] u1_waddr_i,
    input  logic [DATA_W-1:0]     u1_wdata_i,
    output logic                  u1_ready_o,
    input  logic                  u2_valid_i,
    input  logic [REG_ADDR_W-1:0] u2_waddr_i,
    input  logic [DATA_W-1:0]     u2_wdata_i,
    output logic                  u2_ready_o,
    input  logic                  iss_i,
    input  logic [REG_ADDR_W-1:0] iss_addr_i,
    input  logic [REG_ADDR_W-1:0] chk1_addr_i,
    input  logic [REG_ADDR_W-1:0] chk2_addr_i,
    output logic                  busy1_o,
    output logic                  busy2_o,
    output logic                  stall_o,
    output logic                  we_o,
    output logic [REG_ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0]     wdata_o
);

    typedef enum logic {
        UNIT1 = 1'b0,
        UNIT2 = 1'b1
    } unit_e;

    localparam logic [3:0] CNT_MAX = 4'hF;
    localparam logic [3:0] LIM     = 4'(STARVE_LIM);

    logic                  pipe_act;
    logic                  u1_win;
    logic                  u2_win;
    logic                  grant;
    logic [REG_ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0]     g_data;

    unit_e                 last_q,  last_d;
    logic [NUM_REGS-1:0]   pend_q,  pend_d;
    logic [3:0]            cnt_q,   cnt_d;
    logic                  stall_q, stall_d;
    logic                  we_q,    we_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;

    // Grant decode: a lone valid unit wins outright, a contest goes to the unit
    // that was not granted last. Held low during reset so no transfer completes.
    always_comb begin
        pipe_act = pipe_we_i && (pipe_waddr_i != '0);
        u1_win   = !rst && u1_valid_i && !pipe_act && (!u2_valid_i || last_q == UNIT2);
        u2_win   = !rst && u2_valid_i && !pipe_act && (!u1_valid_i || last_q == UNIT1);
        grant    = u1_win || u2_win;
        g_addr   = u1_win ? u1_waddr_i : u2_waddr_i;
        g_data   = u1_win ? u1_wdata_i : u2_wdata_i;
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned and infers a latch.
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;

        if (pipe_act) begin
            we_d    = 1'b1;
            waddr_d = pipe_waddr_i;
            wdata_d = pipe_wdata_i;
        end else if (grant && g_addr != '0) begin
            we_d    = 1'b1;
            waddr_d = g_addr;
            wdata_d = g_data;
        end

        if (u1_win) begin
            last_d = UNIT1;
        end else if (u2_win) begin
            last_d = UNIT2;
        end

        // Clear before set so an issue on the same edge keeps the register pending.
        if (grant && g_addr != '0) begin
            pend_d[g_addr] = 1'b0;
        end
        if (iss_i && iss_addr_i != '0) begin
            pend_d[iss_addr_i] = 1'b1;
        end
        pend_d[0] = 1'b0;

        if (grant) begin
            cnt_d   = '0;
            stall_d = 1'b0;
        end else begin
            if ((u1_valid_i || u2_valid_i) && cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 4'd1;
            end
            if (cnt_q >= LIM) begin
                stall_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the scoreboard is a flop vector, so it resets like any other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q  <= UNIT2;
            pend_q  <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            last_q  <= last_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign u1_ready_o = u1_win;
    assign u2_ready_o = u2_win;
    assign busy1_o    = !rst && (chk1_addr_i != '0) && pend_q[chk1_addr_i];
    assign busy2_o    = !rst && (chk2_addr_i != '0) && pend_q[chk2_addr_i];
    assign stall_o    = stall_q;
    assign we_o       = we_q;
    assign waddr_o    = waddr_q;
    assign wdata_o    = wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations, then
// random traffic compared every cycle against a behavioural model.
module tb_wb_arbiter;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int LIM = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          pipe_we_i;
    logic [AW-1:0] pipe_waddr_i;
    logic [DW-1:0] pipe_wdata_i;
    logic          u1_valid_i, u2_valid_i;
    logic [AW-1:0] u1_waddr_i, u2_waddr_i;
    logic [DW-1:0] u1_wdata_i, u2_wdata_i;
    logic          u1_ready_o, u2_ready_o;
    logic          iss_i;
    logic [AW-1:0] iss_addr_i, chk1_addr_i, chk2_addr_i;
    logic          busy1_o, busy2_o, stall_o, we_o;
    logic [AW-1:0] waddr_o;
    logic [DW-1:0] wdata_o;

    int n_checks = 0;
    int n_fail   = 0;

    wb_arbiter #(.REG_ADDR_W(AW), .DATA_W(DW), .NUM_REGS(32), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rst(rst),
        .pipe_we_i(pipe_we_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
        .u1_valid_i(u1_valid_i), .u1_waddr_i(u1_waddr_i), .u1_wdata_i(u1_wdata_i), .u1_ready_o(u1_ready_o),
        .u2_valid_i(u2_valid_i), .u2_waddr_i(u2_waddr_i), .u2_wdata_i(u2_wdata_i), .u2_ready_o(u2_ready_o),
        .iss_i(iss_i), .iss_addr_i(iss_addr_i),
        .chk1_addr_i(chk1_addr_i), .chk2_addr_i(chk2_addr_i),
        .busy1_o(busy1_o), .busy2_o(busy2_o), .stall_o(stall_o),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: state after the next rising edge, advanced on each falling edge.
    int          m_last;
    bit          m_pend [32];
    int          m_cnt;
    bit          m_stall;
    bit          m_we;
    int          m_waddr;
    logic [31:0] m_wdata;

    task automatic model_reset();
        m_last  = 2;
        m_cnt   = 0;
        m_stall = 0;
        m_we    = 0;
        m_waddr = 0;
        m_wdata = '0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        if (rst) begin
            check("rst_u1_ready", u1_ready_o, 0);
            check("rst_u2_ready", u2_ready_o, 0);
            check("rst_busy1", busy1_o, 0);
            check("rst_busy2", busy2_o, 0);
            check("rst_we", we_o, 0);
            check("rst_waddr", waddr_o, 0);
            check("rst_wdata", wdata_o, 0);
            check("rst_stall", stall_o, 0);
            model_reset();
        end else begin
            bit          pipe;
            int          win;
            int          gaddr;
            logic [31:0] gdata;
            pipe = pipe_we_i && (int'(pipe_waddr_i) != 0);
            win  = 0;
            if (!pipe) begin
                if (u1_valid_i && u2_valid_i) win = (m_last == 1) ? 2 : 1;
                else if (u1_valid_i)          win = 1;
                else if (u2_valid_i)          win = 2;
            end
            gaddr = (win == 1) ? int'(u1_waddr_i) : int'(u2_waddr_i);
            gdata = (win == 1) ? u1_wdata_i : u2_wdata_i;

            check("mdl_u1_ready", u1_ready_o, 32'(win == 1));
            check("mdl_u2_ready", u2_ready_o, 32'(win == 2));
            check("mdl_busy1", busy1_o, 32'(chk1_addr_i != 0 && m_pend[chk1_addr_i]));
            check("mdl_busy2", busy2_o, 32'(chk2_addr_i != 0 && m_pend[chk2_addr_i]));
            check("mdl_we", we_o, 32'(m_we));
            check("mdl_stall", stall_o, 32'(m_stall));
            if (m_we) begin
                check("mdl_waddr", waddr_o, m_waddr);
                check("mdl_wdata", wdata_o, m_wdata);
            end

            if (pipe) begin
                m_we = 1; m_waddr = int'(pipe_waddr_i); m_wdata = pipe_wdata_i;
            end else if (win != 0 && gaddr != 0) begin
                m_we = 1; m_waddr = gaddr; m_wdata = gdata;
            end else begin
                m_we = 0;
            end

            if (win != 0) m_stall = 0;
            else if (m_cnt >= LIM) m_stall = 1;

            if (win != 0) m_cnt = 0;
            else if (u1_valid_i || u2_valid_i) m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;

            if (win != 0 && gaddr != 0) m_pend[gaddr] = 0;
            if (iss_i && iss_addr_i != 0) m_pend[iss_addr_i] = 1;
            if (win != 0) m_last = win;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        u1_valid_i = 1'b0; u2_valid_i = 1'b0; pipe_we_i = 1'b0; iss_i = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        bit g1, g2;
        int dens;
        rst = 1'b1;
        pipe_we_i = 0; pipe_waddr_i = '0; pipe_wdata_i = '0;
        u1_valid_i = 1; u1_waddr_i = 5'd4; u1_wdata_i = 32'h11;
        u2_valid_i = 1; u2_waddr_i = 5'd6; u2_wdata_i = 32'h22;
        iss_i = 0; iss_addr_i = '0; chk1_addr_i = '0; chk2_addr_i = '0;

        // Reset values, with both units requesting while reset is held.
        step();
        check("reset_we", we_o, 0);
        check("reset_waddr", waddr_o, 0);
        check("reset_wdata", wdata_o, 0);
        check("reset_stall", stall_o, 0);
        check("reset_u1_ready", u1_ready_o, 0);
        check("reset_u2_ready", u2_ready_o, 0);
        u1_valid_i = 0; u2_valid_i = 0;
        step();
        rst = 1'b0;

        // Pipe only.
        step();
        pipe_we_i = 1; pipe_waddr_i = 5'd5; pipe_wdata_i = 32'hDEADBEEF;
        #1;
        check("pipe_u1_ready", u1_ready_o, 0);
        check("pipe_u2_ready", u2_ready_o, 0);
        step();
        pipe_we_i = 0;
        check("pipe_we", we_o, 1);
        check("pipe_waddr", waddr_o, 5);
        check("pipe_wdata", wdata_o, 32'hDEADBEEF);

        // Contention: pipe blocks u1 until it goes idle.
        pipe_we_i = 1; pipe_waddr_i = 5'd3; pipe_wdata_i = 32'h33;
        u1_valid_i = 1; u1_waddr_i = 5'd7; u1_wdata_i = 32'h77;
        #1;
        check("cont_blocked", u1_ready_o, 0);
        step();
        pipe_we_i = 0;
        #1;
        check("cont_granted", u1_ready_o, 1);
        step();
        u1_valid_i = 0;
        check("cont_we", we_o, 1);
        check("cont_waddr", waddr_o, 7);

        // Round-robin from reset: u1 first, then alternating, write every cycle.
        do_reset();
        u1_valid_i = 1; u1_waddr_i = 5'd10; u1_wdata_i = 32'hA0;
        u2_valid_i = 1; u2_waddr_i = 5'd11; u2_wdata_i = 32'hB0;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_u1_ready", u1_ready_o, 32'(k % 2 == 0));
            check("rr_u2_ready", u2_ready_o, 32'(k % 2 == 1));
            step();
            check("rr_we", we_o, 1);
            check("rr_waddr", waddr_o, (k % 2 == 0) ? 10 : 11);
        end
        u1_valid_i = 0; u2_valid_i = 0;

        // Scoreboard set, then clear by a u2 grant aligned with we_o.
        iss_i = 1; iss_addr_i = 5'd9; chk1_addr_i = 5'd9;
        step();
        iss_i = 0;
        check("sb_busy_set", busy1_o, 1);
        u2_valid_i = 1; u2_waddr_i = 5'd9; u2_wdata_i = 32'h99;
        #1;
        check("sb_u2_ready", u2_ready_o, 1);
        check("sb_busy_before", busy1_o, 1);
        step();
        u2_valid_i = 0;
        check("sb_busy_clear", busy1_o, 0);
        check("sb_we", we_o, 1);
        check("sb_waddr", waddr_o, 9);

        // Set and clear of r9 on the same edge: set wins.
        iss_i = 1; iss_addr_i = 5'd9;
        step();
        u2_valid_i = 1; u2_waddr_i = 5'd9;
        #1;
        check("sb_same_ready", u2_ready_o, 1);
        step();
        iss_i = 0; u2_valid_i = 0;
        check("sb_same_busy", busy1_o, 1);

        // Starvation: pipe blocks u1; stall visible after LIM+1 denied cycles.
        pipe_we_i = 1; pipe_waddr_i = 5'd1; pipe_wdata_i = 32'h1;
        u1_valid_i = 1; u1_waddr_i = 5'd12; u1_wdata_i = 32'hC0;
        for (int i = 1; i <= LIM + 1; i++) begin
            check("starve_low", stall_o, 0);
            step();
        end
        check("starve_high", stall_o, 1);
        check("starve_denied", u1_ready_o, 0);
        pipe_we_i = 0;
        #1;
        check("starve_grant", u1_ready_o, 1);
        step();
        u1_valid_i = 0;
        check("starve_cleared", stall_o, 0);
        check("starve_waddr", waddr_o, 12);

        // Unit write to r0 is consumed without a register file write.
        u1_valid_i = 1; u1_waddr_i = 5'd0; u1_wdata_i = 32'h55;
        #1;
        check("zero_ready", u1_ready_o, 1);
        step();
        u1_valid_i = 0;
        check("zero_we", we_o, 0);

        // Fill pending to 0xFFFFFFFE, then reset in the middle of a grant.
        for (int r = 1; r < 32; r++) begin
            iss_i = 1; iss_addr_i = 5'(r);
            step();
        end
        iss_i = 0;
        chk1_addr_i = 5'd31; chk2_addr_i = 5'd1;
        #1;
        check("full_busy1", busy1_o, 1);
        check("full_busy2", busy2_o, 1);
        u1_valid_i = 1; u1_waddr_i = 5'd20; u1_wdata_i = 32'hEE;
        #1;
        check("midrst_ready_pre", u1_ready_o, 1);
        rst = 1;
        #1;
        check("midrst_ready", u1_ready_o, 0);
        check("midrst_busy1", busy1_o, 0);
        check("midrst_busy2", busy2_o, 0);
        check("midrst_we", we_o, 0);
        check("midrst_waddr", waddr_o, 0);
        check("midrst_wdata", wdata_o, 0);
        check("midrst_stall", stall_o, 0);
        u1_valid_i = 0;
        step();
        step();
        rst = 0;
        #1;
        check("postrst_busy1", busy1_o, 0);
        check("postrst_busy2", busy2_o, 0);

        // Random traffic; units obey the hold-until-accepted handshake.
        dens = 1;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            g1 = u1_ready_o;
            g2 = u2_ready_o;
            @(posedge clk);
            #1;
            if (n % 250 == 0) dens = $urandom_range(0, 9);
            if (n % 700 == 350) begin
                rst = 1; u1_valid_i = 0; u2_valid_i = 0;
            end else begin
                rst = 0;
                if (!u1_valid_i || g1) begin
                    u1_valid_i = ($urandom % 3) != 0;
                    u1_waddr_i = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
                    u1_wdata_i = $urandom;
                end
                if (!u2_valid_i || g2) begin
                    u2_valid_i = ($urandom % 3) != 0;
                    u2_waddr_i = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
                    u2_wdata_i = $urandom;
                end
            end
            pipe_we_i    = $urandom_range(0, 9) < dens;
            pipe_waddr_i = 5'($urandom_range(0, 7));
            pipe_wdata_i = $urandom;
            iss_i        = ($urandom % 3) == 0;
            iss_addr_i   = 5'($urandom_range(0, 7));
            chk1_addr_i  = 5'($urandom_range(0, 7));
            chk2_addr_i  = 5'($urandom_range(0, 7));
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter and pending-register scoreboard for the single write port of the core's 32×32 register file. It merges three writers onto that port and registers the result: the in-order pipeline writeback, the multi-cycle divider (unit 1) and the load unit (unit 2). It also tracks which destination registers still await a long-latency result, so decode can stall on RAW/WAW hazards. It sits between the EX/MEM/WB stages plus the long-latency units and the register file write port.

## Interface
- REG_ADDR_W, 5, register address width
- DATA_W, 32, register data width
- NUM_REGS, 32, register count (scoreboard width)
- STARVE_LIM, 8, consecutive denied cycles before stall_o is raised (range 1..15)

Ports:
- clk  in  1  core clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- pipe_we_i  in  1  pipeline writeback enable
- pipe_waddr_i  in  REG_ADDR_W  pipeline destination
- pipe_wdata_i  in  DATA_W  pipeline data
- u1_valid_i / u2_valid_i  in  1  unit result pending
- u1_waddr_i / u2_waddr_i  in  REG_ADDR_W  unit destination
- u1_wdata_i / u2_wdata_i  in  DATA_W  unit data
- u1_ready_o / u2_ready_o  out  1  unit result accepted this cycle
- iss_i  in  1  long-latency op issued this cycle
- iss_addr_i  in  REG_ADDR_W  its destination
- chk1_addr_i / chk2_addr_i  in  REG_ADDR_W  decode source addresses
- busy1_o / busy2_o  out  1  addressed register pending
- stall_o  out  1  request pipeline freeze (starvation relief)
- we_o  out  1  register file write enable
- waddr_o  out  REG_ADDR_W  register file write address
- wdata_o  out  DATA_W  register file write data

## Operation
- pipe_act = pipe_we_i && pipe_waddr_i != 0. Pipeline writeback has absolute priority and is never back-pressured.
- When !pipe_act, u1 and u2 arbitrate round-robin. Pointer `last` holds the last granted unit; reset value selects u2, so u1 wins the first contest.
  - A sole valid unit wins immediately.
  - Both valid: the unit other than `last` wins.
- ux_ready_o is combinational: high only for the winner (valid && !pipe_act && selected). At most one ready per cycle.
- Handshake: a unit holds valid, waddr and wdata stable until sampled with ready=1. The transfer completes on that edge.
- Granted write with address 0 is consumed (ready=1), but we_o stays 0 next cycle and no scoreboard change occurs.
- Scoreboard pending[NUM_REGS-1:0]:
  - iss_i sets pending[iss_addr_i]; address 0 is ignored.
  - A unit grant clears pending[ux_waddr_i].
  - Same-edge set and clear of the same address: set wins.
  - Pipeline writes never touch pending.
- busyN_o = pending[chkN_addr_i] && chkN_addr_i != 0. Combinational from registered state.
- Starvation:
  - 4-bit counter increments each cycle any unit is valid and no unit is granted, saturating at 15.
  - The counter clears on any unit grant.
  - stall_o is registered: set when the counter reaches STARVE_LIM; cleared at the edge following a unit grant.
- Reset mid-operation: all state is cleared asynchronously, including pending bits and in-flight unit grants. Units must drop valid on reset.

## Timing
- Reset values: we_o=0, waddr_o=0, wdata_o=0, stall_o=0, pending=0, counter=0, last=u2. u1/u2_ready_o=0 and busy1/2_o=0 while rst=1.
- Latency: the winner is sampled on edge N; we_o/waddr_o/wdata_o are valid during cycle N+1 (one cycle).
- The pending bit falls at the same edge N, so busy drops in cycle N+1, aligned with we_o. The register file's same-cycle bypass then delivers the data to decode.
- iss_i at edge N makes busy visible from cycle N+1.
- With no winner, we_o=0 next cycle; waddr_o/wdata_o hold their previous values.
- stall_o rises one cycle after the counter reaches STARVE_LIM. A continuously pipe-blocked unit therefore sees stall_o high after STARVE_LIM+1 denied cycles.

## Test plan
- Pipe only: pipe_we_i=1, addr 5, data 0xDEADBEEF -> next cycle we_o=1, waddr_o=5, wdata_o=0xDEADBEEF. Ready outputs stay 0.
- Contention: pipe writes r3 while u1 is valid for r7 -> u1_ready_o=0. The cycle pipe goes idle, u1_ready_o=1; next cycle we_o=1, waddr_o=7.
- Round-robin: u1 and u2 both valid continuously from reset, no pipe -> grants alternate u1, u2, u1, u2. we_o is high every cycle.
- Scoreboard:
  - iss_i for r9 -> busy1_o=1 with chk1=9 from the next cycle. After the u2 grant of r9, busy1_o=0 in the same cycle we_o=1.
  - iss r9 and the u2 clear of r9 on the same edge -> busy1_o stays 1.
- Starvation: pipe writes r1 every cycle while u1 is valid -> stall_o=1 after 9 cycles. Drop pipe -> u1 granted; stall_o=0 on the following cycle.
- Zero/reset:
  - u1 writes r0 -> u1_ready_o=1, we_o stays 0.
  - Assert rst mid-grant with pending=0xFFFFFFFE -> all outputs and pending read 0 immediately.
